// File: rtl/my_cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, Fun3 codes,
// immediate formats, ALU operations, mux selects and the control FSM state type.
package my_cpu_pkg;

    localparam int unsigned OPC_W    = 5;
    localparam int unsigned FUN3_W   = 3;
    localparam int unsigned IMMSEL_W = 3;
    localparam int unsigned ALU_W    = 4;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } mc_state_t;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_I      = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_JALR   = 4'd7,
        CLS_LUI    = 4'd8,
        CLS_AUIPC  = 4'd9
    } inst_class_t;

    // inst[6:2] opcodes
    localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;

    localparam logic [FUN3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [FUN3_W-1:0] F3_SLL  = 3'b001;
    localparam logic [FUN3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [FUN3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [FUN3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [FUN3_W-1:0] F3_SR   = 3'b101;
    localparam logic [FUN3_W-1:0] F3_OR   = 3'b110;
    localparam logic [FUN3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUN3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [FUN3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [FUN3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [FUN3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [FUN3_W-1:0] F3_BGEU = 3'b111;

    localparam logic [FUN3_W-1:0] RWTYPE_WORD = 3'b010;

    localparam logic [IMMSEL_W-1:0] IMMGEN_R = 3'd0;
    localparam logic [IMMSEL_W-1:0] IMMGEN_I = 3'd1;
    localparam logic [IMMSEL_W-1:0] IMMGEN_S = 3'd2;
    localparam logic [IMMSEL_W-1:0] IMMGEN_B = 3'd3;
    localparam logic [IMMSEL_W-1:0] IMMGEN_U = 3'd4;
    localparam logic [IMMSEL_W-1:0] IMMGEN_J = 3'd5;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_W-1:0] ALU_EQ   = 4'd10;
    localparam logic [ALU_W-1:0] ALU_NE   = 4'd11;
    localparam logic [ALU_W-1:0] ALU_LT   = 4'd12;
    localparam logic [ALU_W-1:0] ALU_GE   = 4'd13;
    localparam logic [ALU_W-1:0] ALU_LTU  = 4'd14;
    localparam logic [ALU_W-1:0] ALU_GEU  = 4'd15;

    localparam logic [1:0] PCSRC_PC4 = 2'd0;
    localparam logic [1:0] PCSRC_IMM = 2'd1;
    localparam logic [1:0] PCSRC_ALU = 2'd2;

    localparam logic [1:0] ALUB_RS2  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [1:0] ALUB_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 3'd3;

    // Arithmetic op for OP / OP-IMM; Fun7 selects SUB only for register ops.
    function automatic logic [ALU_W-1:0] alu_arith(input logic [FUN3_W-1:0] f3,
                                                   input logic              f7,
                                                   input logic              is_reg);
        logic [ALU_W-1:0] op;
        case (f3)
            F3_ADD:  op = (is_reg && f7) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = f7 ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/my_cpu_inst_decode.sv
// Combinational instruction classifier: class, immediate format, ALU op and legality.
module my_cpu_inst_decode
    import my_cpu_pkg::*;
(
    input  logic [1:0]          inst_low,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUN3_W-1:0]   fun3,
    input  logic                fun7,
    output inst_class_t         cls_c,
    output logic [IMMSEL_W-1:0] imm_sel_c,
    output logic [ALU_W-1:0]    alu_ctrl_c,
    output logic                legal_c
);

    logic known_c;

    always_comb begin
        cls_c      = CLS_NONE;
        imm_sel_c  = IMMGEN_R;
        alu_ctrl_c = ALU_ADD;
        known_c    = 1'b1;
        case (opcode)
            OPC_OP: begin
                cls_c      = CLS_R;
                alu_ctrl_c = alu_arith(fun3, fun7, 1'b1);
            end
            OPC_OP_IMM: begin
                cls_c      = CLS_I;
                imm_sel_c  = IMMGEN_I;
                alu_ctrl_c = alu_arith(fun3, fun7, 1'b0);
            end
            OPC_LOAD: begin
                cls_c     = CLS_LOAD;
                imm_sel_c = IMMGEN_I;
            end
            OPC_STORE: begin
                cls_c     = CLS_STORE;
                imm_sel_c = IMMGEN_S;
            end
            OPC_BRANCH: begin
                cls_c     = CLS_BRANCH;
                imm_sel_c = IMMGEN_B;
                case (fun3)
                    F3_BEQ:  alu_ctrl_c = ALU_EQ;
                    F3_BNE:  alu_ctrl_c = ALU_NE;
                    F3_BLT:  alu_ctrl_c = ALU_LT;
                    F3_BGE:  alu_ctrl_c = ALU_GE;
                    F3_BLTU: alu_ctrl_c = ALU_LTU;
                    F3_BGEU: alu_ctrl_c = ALU_GEU;
                    default: known_c    = 1'b0;
                endcase
            end
            OPC_JAL: begin
                cls_c     = CLS_JAL;
                imm_sel_c = IMMGEN_J;
            end
            OPC_JALR: begin
                cls_c     = CLS_JALR;
                imm_sel_c = IMMGEN_I;
            end
            OPC_LUI: begin
                cls_c     = CLS_LUI;
                imm_sel_c = IMMGEN_U;
            end
            OPC_AUIPC: begin
                cls_c     = CLS_AUIPC;
                imm_sel_c = IMMGEN_U;
            end
            default: known_c = 1'b0;
        endcase
    end

    assign legal_c = known_c && (inst_low == 2'b11);

endmodule

// File: rtl/my_cpu_mc_control.sv
// Multi-cycle RV32I control FSM: BOOT/FETCH/DECODE/EXEC/MEM/WB/TRAP with a
// ready-handshaked shared memory, bounded wait states and sticky trap causes.
module my_cpu_mc_control
    import my_cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned TIMEOUT_W      = 4,
    parameter bit          TRAP_EN        = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          inst_low,
    input  logic [OPC_W-1:0]    OPcode,
    input  logic [FUN3_W-1:0]   Fun3,
    input  logic                Fun7,
    input  logic                alu_cmp,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                MemRW,
    output logic [FUN3_W-1:0]   RWType,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                ALUSrc_A,
    output logic [1:0]          ALUSrc_B,
    output logic [IMMSEL_W-1:0] ImmSel,
    output logic [ALU_W-1:0]    ALU_Control,
    output logic [1:0]          MemtoReg,
    output logic                RegWrite,
    output logic                illegal_inst,
    output logic                mem_timeout,
    output logic [2:0]          state
);

    localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    mc_state_t            state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;

    inst_class_t          cls_c;
    logic [IMMSEL_W-1:0]  imm_sel_c;
    logic [ALU_W-1:0]     alu_ctrl_c;
    logic                 legal_c;
    logic                 wait_expired_c;

    my_cpu_inst_decode u_decode (
        .inst_low   (inst_low),
        .opcode     (OPcode),
        .fun3       (Fun3),
        .fun7       (Fun7),
        .cls_c      (cls_c),
        .imm_sel_c  (imm_sel_c),
        .alu_ctrl_c (alu_ctrl_c),
        .legal_c    (legal_c)
    );

    // The cycle that would be wait number TIMEOUT_CYCLES traps unless ready arrives.
    assign wait_expired_c = TIMEOUT_EN && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        mem_req     = 1'b0;
        MemRW       = 1'b0;
        RWType      = '0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = PCSRC_PC4;
        ALUSrc_A    = 1'b0;
        ALUSrc_B    = ALUB_RS2;
        ImmSel      = IMMGEN_R;
        ALU_Control = ALU_ADD;
        MemtoReg    = WB_ALU;
        RegWrite    = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req = 1'b1;
                RWType  = RWTYPE_WORD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
                end
            end

            ST_DECODE: begin
                if (legal_c) begin
                    state_d = ST_EXEC;
                end else if (TRAP_EN) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_PC4;
                    state_d = ST_FETCH;
                end
            end

            ST_EXEC: begin
                ImmSel  = imm_sel_c;
                state_d = ST_WB;
                case (cls_c)
                    CLS_R: ALU_Control = alu_ctrl_c;
                    CLS_I: begin
                        ALUSrc_B    = ALUB_IMM;
                        ALU_Control = alu_ctrl_c;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ALUSrc_B    = ALUB_IMM;
                        ALU_Control = alu_ctrl_c;
                        state_d     = ST_MEM;
                    end
                    CLS_AUIPC: begin
                        ALUSrc_A    = 1'b1;
                        ALUSrc_B    = ALUB_IMM;
                        ALU_Control = ALU_ADD;
                    end
                    CLS_BRANCH: begin
                        ALU_Control = alu_ctrl_c;
                        PCWrite     = 1'b1;
                        PCSrc       = alu_cmp ? PCSRC_IMM : PCSRC_PC4;
                        state_d     = ST_FETCH;
                    end
                    CLS_JAL: begin
                        RegWrite = 1'b1;
                        MemtoReg = WB_PC4;
                        PCWrite  = 1'b1;
                        PCSrc    = PCSRC_IMM;
                        state_d  = ST_FETCH;
                    end
                    CLS_JALR: begin
                        ALUSrc_B    = ALUB_IMM;
                        ALU_Control = ALU_ADD;
                        RegWrite    = 1'b1;
                        MemtoReg    = WB_PC4;
                        PCWrite     = 1'b1;
                        PCSrc       = PCSRC_ALU;
                        state_d     = ST_FETCH;
                    end
                    default: ;
                endcase
            end

            // Address operands stay selected so the ALU output is stable for the access.
            ST_MEM: begin
                mem_req     = 1'b1;
                MemRW       = (cls_c == CLS_STORE);
                RWType      = Fun3;
                ALUSrc_B    = ALUB_IMM;
                ImmSel      = imm_sel_c;
                ALU_Control = alu_ctrl_c;
                if (mem_ready) begin
                    if (cls_c == CLS_STORE) begin
                        PCWrite = 1'b1;
                        PCSrc   = PCSRC_PC4;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
                end
            end

            ST_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = PCSRC_PC4;
                if (cls_c == CLS_LOAD) begin
                    MemtoReg = WB_MEM;
                end else if (cls_c == CLS_LUI) begin
                    MemtoReg = WB_IMM;
                end
                state_d = ST_FETCH;
            end

            ST_TRAP: state_d = ST_TRAP;

            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    assign illegal_inst = illegal_q;
    assign mem_timeout  = timeout_q;
    assign state        = state_q;

endmodule

// File: tb/tb_my_cpu_mc_control.sv
// Scoreboard bench for my_cpu_mc_control: per-cycle expected control vectors are
// queued by the stimulus and compared on the falling edge by a monitor.
module tb_my_cpu_mc_control;

    logic       clk;
    logic       rst_n, rst2_n;
    logic [1:0] inst_low;
    logic [4:0] opcode;
    logic [2:0] fun3;
    logic       fun7;
    logic       alu_cmp;
    logic       mem_ready;

    logic       mem_req1, memrw1, irw1, pcw1, sa1, rgw1, ill1, tmo1;
    logic [2:0] rwt1, imm1, st1;
    logic [1:0] pcs1, sb1, m2r1;
    logic [3:0] alu1;
    logic       mem_req2, memrw2, irw2, pcw2, sa2, rgw2, ill2, tmo2;
    logic [2:0] rwt2, imm2, st2;
    logic [1:0] pcs2, sb2, m2r2;
    logic [3:0] alu2;

    my_cpu_mc_control u_dut (
        .clk(clk), .rst_n(rst_n), .inst_low(inst_low), .OPcode(opcode), .Fun3(fun3),
        .Fun7(fun7), .alu_cmp(alu_cmp), .mem_ready(mem_ready), .mem_req(mem_req1),
        .MemRW(memrw1), .RWType(rwt1), .IRWrite(irw1), .PCWrite(pcw1), .PCSrc(pcs1),
        .ALUSrc_A(sa1), .ALUSrc_B(sb1), .ImmSel(imm1), .ALU_Control(alu1),
        .MemtoReg(m2r1), .RegWrite(rgw1), .illegal_inst(ill1), .mem_timeout(tmo1),
        .state(st1)
    );

    my_cpu_mc_control #(.TIMEOUT_CYCLES(15), .TIMEOUT_W(4), .TRAP_EN(1'b0)) u_dut_nt (
        .clk(clk), .rst_n(rst2_n), .inst_low(inst_low), .OPcode(opcode), .Fun3(fun3),
        .Fun7(fun7), .alu_cmp(alu_cmp), .mem_ready(mem_ready), .mem_req(mem_req2),
        .MemRW(memrw2), .RWType(rwt2), .IRWrite(irw2), .PCWrite(pcw2), .PCSrc(pcs2),
        .ALUSrc_A(sa2), .ALUSrc_B(sb2), .ImmSel(imm2), .ALU_Control(alu2),
        .MemtoReg(m2r2), .RegWrite(rgw2), .illegal_inst(ill2), .mem_timeout(tmo2),
        .state(st2)
    );

    // {state, mem_req, MemRW, RWType, IRWrite, PCWrite, PCSrc, ALUSrc_A, ALUSrc_B,
    //  ImmSel, ALU_Control, MemtoReg, RegWrite, illegal_inst, mem_timeout}
    logic [26:0] act1, act2;
    assign act1 = {st1, mem_req1, memrw1, rwt1, irw1, pcw1, pcs1, sa1, sb1, imm1, alu1,
                   m2r1, rgw1, ill1, tmo1};
    assign act2 = {st2, mem_req2, memrw2, rwt2, irw2, pcw2, pcs2, sa2, sb2, imm2, alu2,
                   m2r2, rgw2, ill2, tmo2};

    typedef struct {
        logic [26:0] v;
        string       tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            checks++;
            if (act1 !== e1.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e1.tag, act1, e1.v);
            end
        end
        if (q2.size() != 0) begin
            e2 = q2.pop_front();
            checks++;
            if (act2 !== e2.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e2.tag, act2, e2.v);
            end
        end
    end

    function automatic logic [26:0] ev(input logic [2:0] st, input logic req, input logic rw,
                                       input logic [2:0] rwt, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic [1:0] m2r, input logic rgw, input logic ill,
                                       input logic tmo);
        return {st, req, rw, rwt, irw, pcw, pcs, sa, sb, imm, alu, m2r, rgw, ill, tmo};
    endfunction

    function automatic logic [26:0] e_boot();
        return ev(3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] e_fetch(input logic rdy);
        return ev(3'd1, 1'b1, 1'b0, 3'b010, rdy, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] e_dec(input logic pcw);
        return ev(3'd2, 1'b0, 1'b0, 3'd0, 1'b0, pcw, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] e_exec(input logic pcw, input logic [1:0] pcs, input logic sa,
                                           input logic [1:0] sb, input logic [2:0] imm,
                                           input logic [3:0] alu, input logic [1:0] m2r,
                                           input logic rgw);
        return ev(3'd3, 1'b0, 1'b0, 3'd0, 1'b0, pcw, pcs, sa, sb, imm, alu, m2r, rgw, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] e_mem(input logic rw, input logic [2:0] rwt, input logic pcw,
                                          input logic [2:0] imm);
        return ev(3'd4, 1'b1, rw, rwt, 1'b0, pcw, 2'd0, 1'b0, 2'd1, imm, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] e_wb(input logic [1:0] m2r);
        return ev(3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, m2r, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] e_trap(input logic ill, input logic tmo);
        return ev(3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 2'd0, 1'b0, ill, tmo);
    endfunction

    task automatic step(input logic rdy, input logic cmp, input logic [26:0] v, input string tag);
        exp_t e;
        mem_ready = rdy;
        alu_cmp   = cmp;
        e.v   = v;
        e.tag = tag;
        q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic rdy, input logic [26:0] v, input string tag);
        exp_t e;
        mem_ready = rdy;
        alu_cmp   = 1'b0;
        e.v   = v;
        e.tag = tag;
        q2.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [4:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [1:0] low);
        opcode   = opc;
        fun3     = f3;
        fun7     = f7;
        inst_low = low;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, e_boot(), "reset_hold");
        step(1'b0, 1'b0, e_boot(), "reset_hold");
        rst_n = 1'b1;
        step(1'b0, 1'b0, e_boot(), "boot_after_release");
    endtask

    initial begin
        rst_n     = 1'b0;
        rst2_n    = 1'b0;
        mem_ready = 1'b0;
        alu_cmp   = 1'b0;
        set_inst(5'b01100, 3'b000, 1'b0, 2'b11);
        @(posedge clk);
        #1;
        do_reset();

        // ADD: 4 cycles with ready tied high
        set_inst(5'b01100, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "add_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "add_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 2'd0, 1'b0), "add_exec");
        step(1'b1, 1'b0, e_wb(2'd0), "add_wb");

        // SUB
        set_inst(5'b01100, 3'b000, 1'b1, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "sub_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "sub_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd1, 2'd0, 1'b0), "sub_exec");
        step(1'b1, 1'b0, e_wb(2'd0), "sub_wb");

        // SRAI: immediate shift honours Fun7
        set_inst(5'b00100, 3'b101, 1'b1, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "srai_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "srai_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd1, 3'd1, 4'd7, 2'd0, 1'b0), "srai_exec");
        step(1'b1, 1'b0, e_wb(2'd0), "srai_wb");

        // ADDI with inst[30] set is still ADD
        set_inst(5'b00100, 3'b000, 1'b1, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "addi_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "addi_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd1, 3'd1, 4'd0, 2'd0, 1'b0), "addi_exec");
        step(1'b1, 1'b0, e_wb(2'd0), "addi_wb");

        // LW with two data wait cycles: 7 cycles
        set_inst(5'b00000, 3'b010, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "lw_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd1, 3'd1, 4'd0, 2'd0, 1'b0), "lw_exec");
        step(1'b0, 1'b0, e_mem(1'b0, 3'b010, 1'b0, 3'd1), "lw_mem_wait1");
        step(1'b0, 1'b0, e_mem(1'b0, 3'b010, 1'b0, 3'd1), "lw_mem_wait2");
        step(1'b1, 1'b0, e_mem(1'b0, 3'b010, 1'b0, 3'd1), "lw_mem_done");
        step(1'b1, 1'b0, e_wb(2'd1), "lw_wb");

        // SB: RWType follows Fun3, PC+4 on completion
        set_inst(5'b01000, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "sb_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "sb_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd1, 3'd2, 4'd0, 2'd0, 1'b0), "sb_exec");
        step(1'b1, 1'b0, e_mem(1'b1, 3'b000, 1'b1, 3'd2), "sb_mem");

        // BNE taken, then not taken
        set_inst(5'b11000, 3'b001, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "bne_t_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "bne_t_decode");
        step(1'b1, 1'b1, e_exec(1'b1, 2'd1, 1'b0, 2'd0, 3'd3, 4'd11, 2'd0, 1'b0), "bne_taken_exec");
        step(1'b1, 1'b0, e_fetch(1'b1), "bne_n_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "bne_n_decode");
        step(1'b1, 1'b0, e_exec(1'b1, 2'd0, 1'b0, 2'd0, 3'd3, 4'd11, 2'd0, 1'b0), "bne_not_taken_exec");

        // JAL
        set_inst(5'b11011, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "jal_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "jal_decode");
        step(1'b1, 1'b0, e_exec(1'b1, 2'd1, 1'b0, 2'd0, 3'd5, 4'd0, 2'd2, 1'b1), "jal_exec");

        // JALR
        set_inst(5'b11001, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "jalr_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "jalr_decode");
        step(1'b1, 1'b0, e_exec(1'b1, 2'd2, 1'b0, 2'd1, 3'd1, 4'd0, 2'd2, 1'b1), "jalr_exec");

        // LUI
        set_inst(5'b01101, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "lui_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "lui_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd0, 3'd4, 4'd0, 2'd0, 1'b0), "lui_exec");
        step(1'b1, 1'b0, e_wb(2'd3), "lui_wb");

        // AUIPC
        set_inst(5'b00101, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "auipc_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "auipc_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b1, 2'd1, 3'd4, 4'd0, 2'd0, 1'b0), "auipc_exec");
        step(1'b1, 1'b0, e_wb(2'd0), "auipc_wb");

        // SW stalled in MEM, then reset mid-access
        set_inst(5'b01000, 3'b010, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "sw_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd1, 3'd2, 4'd0, 2'd0, 1'b0), "sw_exec");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_mem(1'b1, 3'b010, 1'b0, 3'd2), "sw_mem_wait");
        do_reset();

        // 14 fetch waits then ready on the 15th cycle: no trap
        set_inst(5'b01100, 3'b000, 1'b0, 2'b11);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, e_fetch(1'b0), "fetch_wait");
        step(1'b1, 1'b0, e_fetch(1'b1), "fetch_ready_at_limit");
        step(1'b1, 1'b0, e_dec(1'b0), "limit_decode");
        step(1'b1, 1'b0, e_exec(1'b0, 2'd0, 1'b0, 2'd0, 3'd0, 4'd0, 2'd0, 1'b0), "limit_exec");
        step(1'b1, 1'b0, e_wb(2'd0), "limit_wb");

        // 15 fetch waits: timeout trap, absorbing
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, e_fetch(1'b0), "fetch_wait_to");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, e_trap(1'b0, 1'b1), "trap_timeout");
        do_reset();

        // Illegal opcode traps
        set_inst(5'b11111, 3'b000, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "ill_opc_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "ill_opc_decode");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, e_trap(1'b1, 1'b0), "trap_illegal_opc");
        do_reset();

        // inst[1:0] != 11 traps
        set_inst(5'b01100, 3'b000, 1'b0, 2'b10);
        step(1'b1, 1'b0, e_fetch(1'b1), "ill_low_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "ill_low_decode");
        step(1'b1, 1'b0, e_trap(1'b1, 1'b0), "trap_illegal_low");
        do_reset();

        // Branch Fun3 011 traps
        set_inst(5'b11000, 3'b011, 1'b0, 2'b11);
        step(1'b1, 1'b0, e_fetch(1'b1), "ill_br_fetch");
        step(1'b1, 1'b0, e_dec(1'b0), "ill_br_decode");
        step(1'b1, 1'b0, e_trap(1'b1, 1'b0), "trap_illegal_branch");
        do_reset();

        // TRAP_EN=0 instance: illegal retires as PC+4
        rst_n  = 1'b0;
        rst2_n = 1'b1;
        set_inst(5'b11111, 3'b000, 1'b0, 2'b11);
        step2(1'b0, e_boot(), "nt_boot");
        step2(1'b1, e_fetch(1'b1), "nt_fetch");
        step2(1'b1, e_dec(1'b1), "nt_decode_skip");
        step2(1'b0, e_fetch(1'b0), "nt_next_fetch");

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
